// File: rtl/jtag_dr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_dr_pkg
// Purpose  : Shared constants, helper function and capture-word layout for
//            the BSCAN user-DR streaming bridge.
// Contents : STATUS_BITS - number of status bits above the result word
//            clog2_min1  - ceil(log2(n)), never less than 1
//            status_t    - status field of the capture word
// Revision : 1.0 - initial release
// ============================================================================
package jtag_dr_pkg;

  localparam int STATUS_BITS = 2;

  // Capture word layout, MSB to LSB: {status_t, result}.
  // The status sits above the result so that the host reads the result first
  // (LSB first on tdo) and the flags last.
  typedef struct packed {
    logic overflow;
    logic result_valid;
  } status_t;

  // ceil(log2(value)), clamped to 1 so that it can size a vector even for
  // value <= 2.
  function automatic int clog2_min1(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tck_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tck_sync_fifo
// Purpose  : Small single-clock FIFO for the tck domain. Registered pointers
//            with an extra wrap bit; the head word is presented directly
//            (no output register), so a push is visible one cycle later.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            clr    - synchronous clear (empties the FIFO)
//            push   - write din (ignored when full unless popping as well)
//            pop    - remove the head word (ignored when empty)
//            din    - write data
//            full   - no free entry
//            empty  - no valid entry
//            dout   - head word, zero while empty
// Revision : 1.0 - initial release
// ============================================================================
module tck_sync_fifo
  import jtag_dr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int c_IDX_W = clog2_min1(DEPTH);
  localparam logic [c_IDX_W:0] c_PTR_ONE = (c_IDX_W + 1)'(1);

  logic [c_IDX_W:0] r_wr_ptr;
  logic [c_IDX_W:0] r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]) &&
                 (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]);

  assign w_do_pop  = pop & ~empty;
  // A push into a full FIFO is only safe when the head leaves in the same
  // cycle; the slot being freed is exactly the one being written.
  assign w_do_push = push & (~full | w_do_pop);

  assign dout = empty ? '0 : r_mem[r_rd_ptr[c_IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !clr) begin
      r_mem[r_wr_ptr[c_IDX_W-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtag_dr_stream.sv
`default_nettype none
// ============================================================================
// Module   : jtag_dr_stream
// Purpose  : BSCAN user-DR bridge in the tck domain. Host DR scans are
//            deserialised (LSB first) into IN_WIDTH-bit words and queued in a
//            FIFO that feeds a valid/ready stream. Each capture loads
//            {overflow, result_valid, result} for readback on tdo.
// Ports    : tck, rst_n         - clock, asynchronous active-low reset
//            tdi / tdo          - BSCAN serial in / out
//            test_logic_reset   - synchronous clear, beats every TAP strobe
//            ir_is_user         - qualifies capture_dr/shift_dr/update_dr
//            capture_dr, shift_dr, update_dr - TAP state strobes
//            m_valid/m_ready/m_data - FIFO head stream
//            result, result_valid   - readback value and its final flag
//            overflow           - sticky, a word was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module jtag_dr_stream
  import jtag_dr_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 tck,
  input  logic                 rst_n,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic                 test_logic_reset,
  input  logic                 ir_is_user,
  input  logic                 capture_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IN_WIDTH-1:0]  m_data,
  input  logic [OUT_WIDTH-1:0] result,
  input  logic                 result_valid,
  output logic                 overflow
);

  localparam int c_CAP_W = OUT_WIDTH + STATUS_BITS;
  localparam int c_CNT_W = clog2_min1(IN_WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(IN_WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [IN_WIDTH-1:0] r_in_shift;
  logic [c_CAP_W-1:0]  r_out_shift;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic                r_overflow;

  logic [IN_WIDTH-1:0] w_in_next;
  status_t             w_status;
  logic                w_capture;
  logic                w_shift;
  logic                w_update;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;

  assign w_capture = ir_is_user & capture_dr;
  assign w_shift   = ir_is_user & shift_dr;
  assign w_update  = ir_is_user & update_dr;

  // Only a scan of at least IN_WIDTH bits carries a complete word.
  assign w_push_req = w_update & (r_bit_cnt == c_CNT_FULL);
  assign w_pop      = ~w_empty & m_ready;
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_push     = w_push_req & ~w_drop;

  assign w_status.overflow     = r_overflow;
  assign w_status.result_valid = result_valid;

  // LSB-first deserialiser: new bits enter at the top, so after any scan of
  // IN_WIDTH or more bits the register holds the last IN_WIDTH of them.
  generate
    if (IN_WIDTH > 1) begin : g_shift_wide
      assign w_in_next = {tdi, r_in_shift[IN_WIDTH-1:1]};
    end else begin : g_shift_single
      assign w_in_next = tdi;
    end
  endgenerate

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_in_shift  <= '0;
      r_out_shift <= '0;
      r_bit_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else if (test_logic_reset) begin
      r_in_shift  <= '0;
      r_out_shift <= '0;
      r_bit_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_shift <= {w_status, result};
        r_bit_cnt   <= '0;
      end else if (w_shift) begin
        r_in_shift  <= w_in_next;
        r_out_shift <= {1'b0, r_out_shift[c_CAP_W-1:1]};
        if (r_bit_cnt != c_CNT_FULL) begin
          r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
        end
      end else if (w_update) begin
        r_bit_cnt <= '0;
      end

      // Read-to-clear on capture; a drop in the same cycle keeps it set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_capture) begin
        r_overflow <= 1'b0;
      end
    end
  end

  tck_sync_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (tck),
    .rst_n (rst_n),
    .clr   (test_logic_reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_in_shift),
    .full  (w_full),
    .empty (w_empty),
    .dout  (m_data)
  );

  assign m_valid  = ~w_empty;
  assign overflow = r_overflow;
  // out_shift is a register, so tdo never sees tdi combinationally.
  assign tdo      = ir_is_user & r_out_shift[0];

endmodule
`default_nettype wire

// File: tb/tb_jtag_dr_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_dr_stream
// Purpose  : Self-checking bench for jtag_dr_stream: a scan-vector table,
//            hand-written corner sequences and randomized scans, all checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_dr_stream;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam int D  = 4;
  localparam int CW = OW + 2;

  logic          tck = 1'b0;
  logic          rst_n = 1'b1;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          test_logic_reset = 1'b0;
  logic          ir_is_user = 1'b1;
  logic          capture_dr = 1'b0;
  logic          shift_dr = 1'b0;
  logic          update_dr = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [IW-1:0] m_data;
  logic [OW-1:0] result = '0;
  logic          result_valid = 1'b0;
  logic          overflow;

  jtag_dr_stream #(
    .IN_WIDTH   (IW),
    .OUT_WIDTH  (OW),
    .FIFO_DEPTH (D)
  ) dut (
    .tck              (tck),
    .rst_n            (rst_n),
    .tdi              (tdi),
    .tdo              (tdo),
    .test_logic_reset (test_logic_reset),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .result           (result),
    .result_valid     (result_valid),
    .overflow         (overflow)
  );

  always #5 tck = ~tck;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_ready = 1'b0;

  // Reference model: words queued, sticky flag, bits shifted in since the
  // last capture/update, and bits still to be read out on tdo.
  logic [IW-1:0] mq[$];
  bit            movf;
  bit            sbits[$];
  bit            mout[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sbits.delete();
    mout.delete();
    movf = 1'b0;
  endtask

  // Applies the rules of one tck edge to the model, using the inputs as they
  // stand just before the edge.
  task automatic model_edge();
    bit            pop;
    bit            push_req;
    logic [IW-1:0] w;
    logic [CW-1:0] cap;
    w = '0;
    push_req = 1'b0;
    if (!rst_n || test_logic_reset) begin
      model_clear();
      return;
    end
    pop = m_ready && (mq.size() > 0);
    if (ir_is_user) begin
      if (capture_dr) begin
        cap = {movf, result_valid, result};
        mout.delete();
        for (int i = 0; i < CW; i++) mout.push_back(cap[i]);
        sbits.delete();
        movf = 1'b0;
      end else if (shift_dr) begin
        sbits.push_back(tdi);
        if (mout.size() > 0) void'(mout.pop_front());
      end else if (update_dr) begin
        if (sbits.size() >= IW) begin
          push_req = 1'b1;
          for (int i = 0; i < IW; i++) w[i] = sbits[sbits.size() - IW + i];
        end
        sbits.delete();
      end
    end
    if (pop) void'(mq.pop_front());
    if (push_req) begin
      if (mq.size() < D) mq.push_back(w);
      else movf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit exp_tdo;
    exp_tdo = ir_is_user && (mout.size() > 0) && mout[0];
    chk("m_valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) chk("m_data", {24'd0, m_data}, {24'd0, mq[0]});
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
    chk("tdo", {31'd0, tdo}, {31'd0, exp_tdo});
  endtask

  // One tck edge; inputs are stable from 1 unit after the previous edge.
  task automatic cycle();
    if (rand_ready) m_ready = 1'($urandom);
    model_edge();
    @(posedge tck);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_tdo", {31'd0, tdo}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    cycle();
    rst_n = 1'b1;
  endtask

  // Capture, nbits shifts (val LSB first), update. rb collects tdo as seen
  // before each shift edge; ovf_cap is the flag right after the capture.
  task automatic scan(input int nbits, input logic [31:0] val,
                      output logic [31:0] rb, output logic ovf_cap);
    rb = '0;
    capture_dr = 1'b1;
    cycle();
    capture_dr = 1'b0;
    ovf_cap = overflow;
    shift_dr = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      tdi = val[i];
      rb[i] = tdo;
      cycle();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
    update_dr = 1'b1;
    cycle();
    update_dr = 1'b0;
  endtask

  // Drains with m_ready=1 for a fixed number of cycles, recording the words.
  task automatic drain(input int cycles, output logic [IW-1:0] got[$]);
    got.delete();
    m_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (m_valid) got.push_back(m_data);
      cycle();
    end
  endtask

  typedef struct {
    int            nbits;
    logic [31:0]   data;
    bit            user;
    bit            exp_push;
    logic [IW-1:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0]   rb;
    logic          oc;
    logic [IW-1:0] got[$];

    vecs[0] = '{8,  32'h4C,  1'b1, 1'b1, 8'h4C};
    vecs[1] = '{5,  32'h15,  1'b1, 1'b0, 8'h00};
    vecs[2] = '{12, 32'hABC, 1'b1, 1'b1, 8'hAB};
    vecs[3] = '{8,  32'hFF,  1'b0, 1'b0, 8'h00};
    vecs[4] = '{16, 32'h1234, 1'b1, 1'b1, 8'h12};
    vecs[5] = '{9,  32'h1A5, 1'b1, 1'b1, 8'hD2};

    #1;
    do_reset();

    // Scan table, downstream always ready.
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ir_is_user = vecs[k].user;
      scan(vecs[k].nbits, vecs[k].data, rb, oc);
      chk("vec_valid", {31'd0, m_valid}, {31'd0, vecs[k].exp_push});
      if (vecs[k].exp_push) chk("vec_data", {24'd0, m_data}, {24'd0, vecs[k].exp_word});
      ir_is_user = 1'b1;
      cycle();
      chk("vec_drained", {31'd0, m_valid}, 32'd0);
    end

    // Readback of result with and without the final flag.
    result = 16'h1234;
    result_valid = 1'b1;
    scan(18, 32'd0, rb, oc);
    chk("readback_valid", rb, 32'h11234);
    result_valid = 1'b0;
    scan(18, 32'd0, rb, oc);
    chk("readback_notvalid", rb, 32'h01234);
    repeat (2) cycle();

    // Overflow: fifth word dropped with downstream stalled.
    do_reset();
    m_ready = 1'b0;
    for (int v = 1; v <= 5; v++) scan(8, 32'(v), rb, oc);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    scan(18, 32'd0, rb, oc);
    chk("ovf_rb1_bit17", {31'd0, rb[17]}, 32'd1);
    chk("ovf_clear_on_capture", {31'd0, oc}, 32'd0);
    // The readback's own zero word hit the full FIFO and was dropped too.
    chk("ovf_reset_by_rb_drop", {31'd0, overflow}, 32'd1);
    drain(8, got);
    chk("drain_count", got.size(), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("drain_word", {24'd0, got[i]}, 32'(i + 1));
    scan(18, 32'd0, rb, oc);
    chk("ovf_rb2_bit17", {31'd0, rb[17]}, 32'd1);
    scan(18, 32'd0, rb, oc);
    chk("ovf_rb3_bit17", {31'd0, rb[17]}, 32'd0);
    repeat (2) cycle();

    // Full FIFO, pop and update in the same cycle: push accepted.
    do_reset();
    m_ready = 1'b0;
    for (int v = 1; v <= 4; v++) scan(8, 32'h10 + 32'(v), rb, oc);
    capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi = 1'((32'h77 >> i) & 1);
      cycle();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
    m_ready = 1'b1;
    update_dr = 1'b1;
    cycle();
    update_dr = 1'b0;
    m_ready = 1'b0;
    chk("fullpop_overflow", {31'd0, overflow}, 32'd0);
    chk("fullpop_head", {24'd0, m_data}, 32'h12);
    drain(8, got);
    chk("fullpop_count", got.size(), 32'd4);
    if (got.size() == 4) chk("fullpop_last", {24'd0, got[3]}, 32'h77);

    // Reset in the middle of a scan discards the partial word.
    do_reset();
    m_ready = 1'b1;
    capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b1;
    repeat (3) cycle();
    shift_dr = 1'b0;
    tdi = 1'b0;
    do_reset();
    scan(8, 32'h52, rb, oc);
    chk("midrst_valid", {31'd0, m_valid}, 32'd1);
    chk("midrst_data", {24'd0, m_data}, 32'h52);
    cycle();
    chk("midrst_single", {31'd0, m_valid}, 32'd0);

    // test_logic_reset during shift wins and restarts the bit count.
    capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b1;
    repeat (5) cycle();
    test_logic_reset = 1'b1;
    cycle();
    test_logic_reset = 1'b0;
    repeat (3) cycle();
    shift_dr = 1'b0;
    tdi = 1'b0;
    update_dr = 1'b1; cycle(); update_dr = 1'b0;
    chk("tlr_no_push", {31'd0, m_valid}, 32'd0);

    // tdo is forced low while the user instruction is not selected.
    result = 16'h0001;
    capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    ir_is_user = 1'b0;
    #1;
    chk("tdo_not_user", {31'd0, tdo}, 32'd0);
    ir_is_user = 1'b1;
    #1;
    chk("tdo_user", {31'd0, tdo}, 32'd1);
    update_dr = 1'b1; cycle(); update_dr = 1'b0;

    // Randomized scans with a randomly stalling downstream.
    rand_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      result = 16'($urandom);
      result_valid = 1'($urandom);
      ir_is_user = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) begin
        test_logic_reset = 1'b1;
        cycle();
        test_logic_reset = 1'b0;
      end
      scan(int'($urandom_range(0, 20)), $urandom, rb, oc);
      repeat ($urandom_range(0, 3)) cycle();
    end
    rand_ready = 1'b0;
    ir_is_user = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
